freq_bin2bcd_seq: RTL



---
 rtl/freq_bin2bcd_seq_pkg.sv | 24 ++
 rtl/bcd_add3_digit.sv | 9 +
 rtl/freq_bin2bcd_seq.sv | 104 ++++++++++
 3 files changed

// File: rtl/freq_bin2bcd_seq_pkg.sv
// Shared constants and FSM encoding for the sequential binary-to-BCD converter.
package freq_bin2bcd_seq_pkg;

  localparam int BIN_W_DEF  = 32;
  localparam int DIGITS_DEF = 6;

  function automatic longint unsigned max_val(input int unsigned digits);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int                  BCD_W     = DIGITS_DEF * 4;
  localparam int                  CNT_W     = $clog2(BIN_W_DEF);
  localparam longint unsigned     MAX_VAL   = max_val(DIGITS_DEF);
  localparam logic [BCD_W-1:0]    ALL_NINES = {DIGITS_DEF{4'h9}};

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets +3 before the shift.
module bcd_add3_digit (
  input  logic [3:0] i_d,
  output logic [3:0] o_d
);

  assign o_d = (i_d >= 4'd5) ? i_d + 4'd3 : i_d;

endmodule

// File: rtl/freq_bin2bcd_seq.sv
// Iterative shift-and-add-3 binary-to-BCD converter, one input bit per clock.
module freq_bin2bcd_seq
  import freq_bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin_in,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [DIGITS*4-1:0]   bcd_out
);

  localparam int                  L_BCD_W = DIGITS * 4;
  localparam int                  L_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
  localparam longint unsigned     L_MAX   = max_val(DIGITS);
  localparam logic [L_BCD_W-1:0]  L_NINES = {DIGITS{4'h9}};

  state_t               r_state;
  state_t               w_state_nxt;
  logic [BIN_W-1:0]     r_bin_sr;
  logic [L_BCD_W-1:0]   r_scratch;
  logic [L_CNT_W-1:0]   r_cnt;
  logic                 r_ovf_pending;
  logic [L_BCD_W-1:0]   r_bcd_out;
  logic                 r_overflow;
  logic                 r_done;

  logic [L_BCD_W-1:0]   w_corr;
  logic [L_BCD_W-1:0]   w_shifted;
  logic                 w_last;
  logic                 w_ovf_in;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3_digit u_add3 (
      .i_d (r_scratch[g*4 +: 4]),
      .o_d (w_corr[g*4 +: 4])
    );
  end

  // Carry out of the top digit is dropped; saturation covers those inputs.
  assign w_shifted = {w_corr[L_BCD_W-2:0], r_bin_sr[BIN_W-1]};
  assign w_last    = (r_cnt == L_CNT_W'(BIN_W - 1));
  assign w_ovf_in  = (64'(bin_in) > L_MAX);

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_nxt = SHIFT;
      SHIFT:   if (w_last) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bin_sr      <= '0;
      r_scratch     <= '0;
      r_cnt         <= '0;
      r_ovf_pending <= 1'b0;
      r_bcd_out     <= '0;
      r_overflow    <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_bin_sr      <= bin_in;
            r_scratch     <= '0;
            r_cnt         <= '0;
            r_ovf_pending <= w_ovf_in;
          end
        end
        SHIFT: begin
          r_scratch <= w_shifted;
          r_bin_sr  <= {r_bin_sr[BIN_W-2:0], 1'b0};
          r_cnt     <= r_cnt + 1'b1;
          if (w_last) begin
            r_bcd_out  <= r_ovf_pending ? L_NINES : w_shifted;
            r_overflow <= r_ovf_pending;
            r_done     <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy     = (r_state == SHIFT);
  assign done     = r_done;
  assign overflow = r_overflow;
  assign bcd_out  = r_bcd_out;

endmodule
